// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: PC generation, one-outstanding-request memory port,
// DEPTH-entry prefetch queue with valid/ready head, redirects, halt and retire counter.
module fetch_prefetch_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_addr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic                   redirect_rel,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   halt_req,
  output logic                   halt,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int FILL_W = OCC_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PC_WIDTH-1:0]    fetch_pc, req_addr, target;
  logic                   outstanding, outstanding_next;
  logic [1:0]             drop_cnt, drop_next;
  logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
  logic [PC_WIDTH-1:0]    q_pc    [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_next;
  logic [OCC_W-1:0]       occ, occ_next, remain;
  logic [FILL_W-1:0]      fill;
  logic                   running, consume, halt_now, redir_now, flush;
  logic                   resp, resp_stale, resp_fresh, push, pop, issue;
  logic                   head_load;
  logic [INSTR_WIDTH-1:0] head_instr_next;
  logic [PC_WIDTH-1:0]    head_pc_next;

  // Stale responses (from before a flush) are counted in drop_cnt rather than
  // blocking issue, so the first fetch to a new target leaves the next cycle.
  always_comb begin
    running    = (state == RUN);
    consume    = running && (occ != '0) && instr_ready;
    halt_now   = consume && halt_req && !start;
    redir_now  = running && redirect && !start && !halt_now;
    flush      = start || halt_now || redir_now;
    resp       = imem_rvalid && (outstanding || (drop_cnt != 2'd0));
    resp_stale = resp && (drop_cnt != 2'd0);
    resp_fresh = resp && (drop_cnt == 2'd0);
    push       = resp_fresh && !flush;
    pop        = consume && !flush;
    fill       = {1'b0, occ} + FILL_W'(push);
    // A slot is reserved for every in-flight request; a saturated drop count also stalls issue.
    issue      = running && !start && !redirect && !halt_now &&
                 (!outstanding || resp_fresh) && (drop_cnt != 2'd3) &&
                 (fill < FILL_W'(DEPTH));
    target     = redirect_rel ? (instr_pc + redirect_target) : redirect_target;
    occ_next   = flush ? '0 : OCC_W'(fill - FILL_W'(pop));
    remain     = occ - OCC_W'(pop);
    rd_next    = rd_ptr + PTR_W'(pop);
    if (flush) begin
      drop_next        = drop_cnt + 2'(outstanding) - 2'(resp);
      outstanding_next = 1'b0;
    end else begin
      drop_next        = drop_cnt - 2'(resp_stale);
      outstanding_next = (outstanding && !resp_fresh) || issue;
    end
  end

  // NOTE: every signal gets a value before any condition so no latch is inferred.
  always_comb begin
    head_load       = 1'b0;
    head_instr_next = imem_rdata;
    head_pc_next    = req_addr;
    if (!flush) begin
      if (remain != '0) begin
        head_load       = 1'b1;
        head_instr_next = q_instr[rd_next];
        head_pc_next    = q_pc[rd_next];
      end else if (push) begin
        head_load = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start)         state_next = RUN;
    else if (halt_now) state_next = HALTED;
  end

  always_comb begin
    imem_req    = issue;
    imem_addr   = fetch_pc;
    instr_valid = (occ != '0);
    halt        = (state == HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      req_addr    <= '0;
      outstanding <= 1'b0;
      drop_cnt    <= 2'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_count <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      occ         <= occ_next;

      if (start)          fetch_pc <= start_addr;
      else if (redir_now) fetch_pc <= target;
      else if (issue)     fetch_pc <= fetch_pc + PC_WIDTH'(1);

      if (issue) req_addr <= fetch_pc;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        rd_ptr <= rd_next;
      end

      // Head registers hold their last value while the queue is empty.
      if (head_load) begin
        instr    <= head_instr_next;
        instr_pc <= head_pc_next;
      end

      if (start)                             instr_count <= '0;
      else if (consume && !(&instr_count))   instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers guarantee
  // only written entries are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= req_addr;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order variable-latency memory model plus a
// scoreboard of expected fetch addresses and retired instructions.
module tb_fetch_prefetch_unit;

  localparam int PW = 10;
  localparam int IW = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, start, imem_req, imem_rvalid, instr_valid, instr_ready;
  logic          redirect, redirect_rel, halt_req, halt;
  logic [PW-1:0] start_addr, imem_addr, instr_pc, redirect_target;
  logic [IW-1:0] imem_rdata, instr;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    logic [PW-1:0] addr;
    int            due;
  } mem_req_t;

  mem_req_t      mem_q[$];
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] req_log[$];
  logic [PW-1:0] cons_log[$];
  logic          model_run = 1'b0;
  logic [PW-1:0] model_pc  = '0;
  logic [CW-1:0] model_cnt = '0;
  logic [PW-1:0] last_pc   = '0;

  fetch_prefetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_rel(redirect_rel), .redirect_target(redirect_target),
    .halt_req(halt_req), .halt(halt), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_data(input logic [PW-1:0] a);
    return a[IW-1:0] ^ {a[PW-1], 8'h5A};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Memory: responds in request order, lat cycles after the request cycle.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: predicts fetch addresses and retired instructions from the stimulus.
  initial begin : monitor
    logic [PW-1:0] hp, e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("instr_count", instr_count, model_cnt);
        hp = (exp_q.size() != 0) ? exp_q[0] : last_pc;
        if (model_run && instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_empty", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e);
            check("instr", instr, mem_data(e));
            cons_log.push_back(instr_pc);
            last_pc = e;
          end
          if (!start && model_cnt != '1) model_cnt++;
          if (halt_req && !start) begin
            model_run = 1'b0;
            exp_q.delete();
          end
        end
        if (model_run && redirect && !start) begin
          model_pc = redirect_rel ? hp + redirect_target : redirect_target;
          exp_q.delete();
        end
        if (start) begin
          model_run = 1'b1;
          model_pc  = start_addr;
          model_cnt = '0;
          exp_q.delete();
        end
        if (imem_req) begin
          req_log.push_back(imem_addr);
          mem_q.push_back('{imem_addr, cyc + lat});
          if (!model_run) begin
            check("req_stopped", imem_req, 0);
          end else begin
            check("imem_addr", imem_addr, model_pc);
            exp_q.push_back(model_pc);
            model_pc++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [PW-1:0] a);
    req_log.delete();
    cons_log.delete();
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  task automatic do_redirect(input logic rel, input logic [PW-1:0] t);
    req_log.delete();
    cons_log.delete();
    redirect        = 1'b1;
    redirect_rel    = rel;
    redirect_target = t;
    tick();
    redirect        = 1'b0;
    redirect_rel    = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (int'(instr_count) < target && n < budget) begin
      tick();
      n++;
    end
    if (int'(instr_count) < target) check("wait_count", instr_count, target);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    if (!instr_valid) check("wait_valid", instr_valid, 1);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halt && n < budget) begin
      tick();
      n++;
    end
    if (!halt) check("wait_halt", halt, 1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_imem_req"}, imem_req, 0);
    check({pfx, "_imem_addr"}, imem_addr, 0);
    check({pfx, "_instr_valid"}, instr_valid, 0);
    check({pfx, "_instr"}, instr, 0);
    check({pfx, "_instr_pc"}, instr_pc, 0);
    check({pfx, "_halt"}, halt, 0);
    check({pfx, "_instr_count"}, instr_count, 0);
  endtask

  task automatic check_log(input string tag, input logic [PW-1:0] q[$], input int idx,
                           input logic [PW-1:0] want);
    if (q.size() <= idx) check({tag, "_len"}, q.size(), idx + 1);
    else                 check(tag, q[idx], want);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_rel = 1'b0; redirect_target = '0; halt_req = 1'b0;
    tick(2);
    check_zero("por");
    reset = 1'b0;
    tick(3);
    check("idle_req", imem_req, 0);

    // Straight-line fetch, latency 1, decoder always ready.
    lat = 1; instr_ready = 1'b1;
    pulse_start(10'h010);
    wait_count(3, 40);
    check("t1_count", instr_count, 3);
    for (int i = 0; i < 3; i++) begin
      check_log("t1_req", req_log, i, 10'h010 + PW'(i));
      check_log("t1_pop", cons_log, i, 10'h010 + PW'(i));
    end

    // Backpressure: queue fills with exactly DEPTH requests, then drains.
    instr_ready = 1'b0; lat = 2;
    pulse_start(10'h000);
    tick(20);
    check("t2_nreq", req_log.size(), 4);
    for (int i = 0; i < 4; i++) check_log("t2_req", req_log, i, PW'(i));
    check("t2_valid", instr_valid, 1);
    check("t2_req_full", imem_req, 0);
    instr_ready = 1'b1;
    tick(12);
    for (int i = 0; i < 4; i++) check_log("t2_pop", cons_log, i, PW'(i));
    check_log("t2_resume", req_log, 4, 10'h004);

    // Absolute redirect with a request in flight: stale response dropped.
    lat = 3;
    pulse_start(10'h040);
    tick(1);
    do_redirect(1'b0, 10'h080);
    check("t3_flushed", instr_valid, 0);
    tick(12);
    check_log("t3_req", req_log, 0, 10'h080);
    check_log("t3_pop", cons_log, 0, 10'h080);

    // Relative redirects, negative offset and wrap-around.
    instr_ready = 1'b0; lat = 1;
    pulse_start(10'h005);
    wait_valid(20);
    check("t4_head_a", instr_pc, 10'h005);
    do_redirect(1'b1, 10'h3FE);
    tick(3);
    check_log("t4_rel_neg", req_log, 0, 10'h003);
    pulse_start(10'h3FF);
    wait_valid(20);
    check("t4_head_b", instr_pc, 10'h3FF);
    do_redirect(1'b1, 10'h002);
    tick(3);
    check_log("t4_rel_wrap", req_log, 0, 10'h001);

    // Halt on the seventh retire, late response ignored, restart clears.
    lat = 3; instr_ready = 1'b1;
    pulse_start(10'h100);
    wait_count(6, 200);
    halt_req = 1'b1;
    wait_halt(40);
    halt_req = 1'b0;
    check("t5_halt", halt, 1);
    check("t5_count", instr_count, 7);
    check("t5_req", imem_req, 0);
    tick(8);
    check("t5_count_frozen", instr_count, 7);
    check("t5_valid_late", instr_valid, 0);
    check("t5_req_late", imem_req, 0);
    check("t5_halt_held", halt, 1);
    pulse_start(10'h020);
    check("t5_unhalt", halt, 0);
    check("t5_count_clr", instr_count, 0);
    tick(8);
    check_log("t5_restart", req_log, 0, 10'h020);

    // Asynchronous reset between edges.
    lat = 1;
    tick(6);
    @(posedge clk);
    #3;
    reset = 1'b1;
    mem_q.delete(); exp_q.delete();
    model_run = 1'b0; model_pc = '0; model_cnt = '0; last_pc = '0;
    #1;
    check_zero("async");
    tick(2);
    reset = 1'b0;
    tick(2);

    // start and redirect together while running: start_addr wins.
    pulse_start(10'h300);
    tick(3);
    req_log.delete();
    start = 1'b1; start_addr = 10'h0C0;
    redirect = 1'b1; redirect_rel = 1'b0; redirect_target = 10'h1F0;
    tick();
    start = 1'b0; redirect = 1'b0;
    tick(4);
    check_log("t6_start_wins", req_log, 0, 10'h0C0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the single-cycle fetch unit. Holds the PC, issues requests to a variable-latency instruction memory, and buffers returned instructions in a DEPTH-entry prefetch queue. It presents them to the decoder through a valid/ready handshake. Also handles start, absolute and PC-relative redirects with flush, halt, and a retired-instruction counter.

Parameters:
PC_WIDTH, 10, width of PC and instruction address; PC wraps modulo 2^PC_WIDTH
INSTR_WIDTH, 9, instruction word width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
CNT_WIDTH, 16, instruction counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: load start_addr, flush, clear counter, begin fetching
start_addr  in  PC_WIDTH  initial PC, sampled when start=1
imem_req  out  1  request valid, one cycle per request
imem_addr  out  PC_WIDTH  request address, valid with imem_req
imem_rvalid  in  1  response valid
imem_rdata  in  INSTR_WIDTH  response data, valid with imem_rvalid
instr_valid  out  1  queue head valid
instr  out  INSTR_WIDTH  queue head instruction
instr_pc  out  PC_WIDTH  address of queue head
instr_ready  in  1  decoder accepts head
redirect  in  1  taken branch/jump, 1-cycle pulse
redirect_rel  in  1  1: target = instr_pc + offset; 0: target = redirect_target
redirect_target  in  PC_WIDTH  absolute target, or signed two's-complement offset when redirect_rel=1
halt_req  in  1  head instruction is halt, qualified by handshake
halt  out  1  core halted
instr_count  out  CNT_WIDTH  instructions consumed since start

Behaviour:
- Reset (async): state IDLE; fetch PC=0; queue empty; no outstanding request; drop flag=0.
- Reset outputs: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, halt=0, instr_count=0.
- States: IDLE -> RUN on start. RUN -> HALTED on a consume (instr_valid & instr_ready) with halt_req=1. HALTED -> RUN on start. start in any state re-enters RUN.
- start: fetch PC <= start_addr; queue flushed; instr_count <= 0. If a request is outstanding, set drop flag.
- Issue rule, RUN only: imem_req=1 when no request is outstanding, no redirect/start this cycle, and occupancy < DEPTH. imem_addr = fetch PC; fetch PC increments by 1 on issue.
- At most one request is outstanding. Latency is arbitrary, >=1 cycle. imem_rvalid with no outstanding request is ignored.
- Response: if drop flag=1, discard the data and clear the flag. Otherwise push {imem_rdata, request addr} into the queue and clear outstanding.
- Response and pop in the same cycle at full: both occur, occupancy unchanged.
- Same cycle as a response, a new request may issue (back-to-back).
- Consume: pop head; instr_count += 1, saturating at all-ones. instr/instr_pc show the new head next cycle.
- Queue empty: instr_valid=0; instr and instr_pc hold their last values.
- Redirect (RUN only): target = redirect_rel ? (instr_pc + redirect_target) mod 2^PC_WIDTH : redirect_target.
  - Fetch PC <= target; queue flushed the same edge; drop flag set if a request is outstanding.
  - A consume in the same cycle still counts (the branch retires).
  - First request to the target issues the cycle after redirect.
- halt_req is ignored without the handshake. On halt: queue flushed, no further requests, halt=1 until start or reset.
- An outstanding response arriving in HALTED is discarded.
- Priority, same cycle: reset > start > halt > redirect > normal fetch.
- redirect and halt_req are ignored in IDLE/HALTED.

Test Plan:
- Reset, then start with start_addr=0x010, latency 1, instr_ready=1 -> imem_addr sequence 0x010,0x011,0x012; instr_pc follows in order; instr_count=3 after 3 consumes.
- instr_ready=0, latency 2 -> exactly DEPTH=4 requests (0x000..0x003); imem_req stays 0 while full. Raise ready -> 4 pops in order, then fetching resumes at 0x004.
- Redirect absolute 0x080 while a request is outstanding (latency 3) -> stale response dropped, queue empty; next imem_addr=0x080; first instr_pc=0x080.
- Relative redirect with instr_pc=0x005, redirect_target=0x3FE (-2) -> next imem_addr=0x003. With instr_pc=0x3FF and offset 0x002 -> imem_addr=0x001 (wrap).
- Consume with halt_req=1 at instr_count=6 -> halt=1, instr_count=7 and frozen, imem_req=0, late response ignored. start with start_addr=0x020 -> halt=0, count=0, fetch from 0x020.
- Assert reset asynchronously mid-run, between clock edges -> all outputs 0 immediately. start and redirect in the same cycle -> start_addr wins.
